// File: rtl/laser_pulse_arbiter.sv
// laser_pulse_arbiter
// Shares one laser between NREQ requesting stations. Requests are granted
// round-robin. Each grant runs one ARM cycle, then a laser-on pulse of
// pulse_len cycles (0 is treated as 1), then cool_len cooldown cycles.
// This block owns the only duration counter, so no requester can drive the
// laser enable directly.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state immediately
//   req        level request per station, sampled only in IDLE
//   pulse_len  laser-on cycles, latched at grant
//   cool_len   cooldown cycles after the pulse, latched at grant
//   abort      ends the current pulse early; honoured in ARM and FIRE only
//   grant      one-hot owner during ARM and FIRE, otherwise 0
//   light      laser enable, high only in FIRE
//   busy       high whenever the block is not IDLE
//   done       one-cycle one-hot pulse on normal pulse completion
//   aborted    one-cycle pulse when a pulse was aborted
module laser_pulse_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NBITS-1:0] pulse_len,
  input  logic [NBITS-1:0] cool_len,
  input  logic             abort,
  output logic [NREQ-1:0]  grant,
  output logic             light,
  output logic             busy,
  output logic [NREQ-1:0]  done,
  output logic             aborted
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ARM, FIRE, COOL} state_t;

  state_t           state_q;
  logic [NREQ-1:0]  grant_q;
  logic [PW-1:0]    gidx_q;
  logic [PW-1:0]    rr_ptr;
  logic [NBITS-1:0] cnt_q;
  logic [NBITS-1:0] len_q;
  logic [NBITS-1:0] cool_q;
  logic [NREQ-1:0]  done_q;
  logic             aborted_q;

  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [NREQ-1:0]  pick_oh;
  logic [PW-1:0]    rr_next;

  // First set request at or above ptr, wrapping modulo NREQ.
  // Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [PW-1:0]   ptr);
    logic          found;
    logic [PW-1:0] idx;
    int            k;
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && r[k[PW-1:0]]) begin
        found = 1'b1;
        idx   = k[PW-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign {pick_vld, pick_idx} = rr_pick(req, rr_ptr);

  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  assign rr_next = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      cool_q    <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= '0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_oh;
            gidx_q  <= pick_idx;
            len_q   <= (pulse_len == '0) ? NBITS'(1) : pulse_len;
            cool_q  <= cool_len;
            state_q <= ARM;
          end
        end
        ARM: begin
          cnt_q  <= '0;
          rr_ptr <= rr_next;
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= (cool_q == '0) ? IDLE : COOL;
          end else begin
            state_q <= FIRE;
          end
        end
        FIRE: begin
          // len_q is at least 1, so len_q - 1 never underflows and the
          // counter stops before it could wrap.
          if (abort || (cnt_q == len_q - 1'b1)) begin
            cnt_q   <= '0;
            state_q <= (cool_q == '0) ? IDLE : COOL;
            if (abort) aborted_q <= 1'b1;
            else       done_q    <= grant_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COOL: begin
          // Only entered with cool_q >= 1.
          if (cnt_q == cool_q - 1'b1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only; the async reset forces
  // state_q to IDLE, so light and grant fall without waiting for a clock.
  assign grant   = (state_q == ARM || state_q == FIRE) ? grant_q : '0;
  assign light   = (state_q == FIRE);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_laser_pulse_arbiter.sv
module tb_laser_pulse_arbiter;

  localparam int K_LIGHT = 0;
  localparam int K_ABORT = 1;
  localparam int K_DONE  = 2;
  localparam int K_IDLE  = 3;
  localparam int K_GRANT = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] pulse_len;
  logic [31:0] cool_len;
  logic        abort;
  logic [3:0]  grant;
  logic        light;
  logic        busy;
  logic [3:0]  done;
  logic        aborted;

  laser_pulse_arbiter #(.NREQ(4), .NBITS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .pulse_len (pulse_len),
    .cool_len  (cool_len),
    .abort     (abort),
    .grant     (grant),
    .light     (light),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == n during cycle n (the period after rising edge n).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t expq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic string kname(int k);
    case (k)
      K_LIGHT: return "LIGHT_LEN";
      K_ABORT: return "ABORTED";
      K_DONE:  return "DONE";
      K_IDLE:  return "IDLE";
      K_GRANT: return "GRANT";
      default: return "UNKNOWN";
    endcase
  endfunction

  task automatic push(int kind, int val, int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    expq.push_back(e);
  endtask

  // Expected events of one grant. ab > 0 means abort is driven during FIRE
  // cycle ab, so light lasts ab cycles. Within a cycle events are pushed in
  // the order the monitor reports them: LIGHT, ABORT, DONE, IDLE, GRANT.
  task automatic expect_pulse(int arm, int g, int l, int c, int ab);
    int lit;
    int e;
    lit = (l == 0) ? 1 : l;
    if (ab > 0) lit = ab;
    e = arm + lit + 1;
    push(K_GRANT, g, arm);
    push(K_LIGHT, lit, e);
    if (ab > 0) push(K_ABORT, 1, e);
    else        push(K_DONE, g, e);
    push(K_IDLE, 0, e + c);
  endtask

  task automatic observe(int kind, int val);
    ev_t e;
    n_checks++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %s val=%0d cycle=%0d, required no event",
               kname(kind), val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got %s val=%0d cycle=%0d, required %s val=%0d cycle=%0d",
                 kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic monitor_loop();
    int   light_run;
    logic prev_busy;
    light_run = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (light) begin
        light_run++;
      end else if (light_run > 0) begin
        observe(K_LIGHT, light_run);
        light_run = 0;
      end
      if (aborted)          observe(K_ABORT, 1);
      if (done != 4'b0)     observe(K_DONE, int'(done));
      if (prev_busy && !busy) observe(K_IDLE, 0);
      if (grant != 4'b0 && !light) observe(K_GRANT, int'(grant));
      prev_busy = busy;
    end
  endtask

  task automatic wait_cyc(int x);
    while (cyc < x) @(negedge clk);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected events still pending, required 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic stimulus();
    int c;
    reset     = 1'b1;
    req       = '0;
    pulse_len = '0;
    cool_len  = '0;
    abort     = 1'b0;

    // Reset state
    wait_cyc(2);
    check("reset_grant",   int'(grant),   0);
    check("reset_light",   int'(light),   0);
    check("reset_busy",    int'(busy),    0);
    check("reset_done",    int'(done),    0);
    check("reset_aborted", int'(aborted), 0);
    reset = 1'b0;

    // Single request, no contention
    wait_cyc(4);
    c = cyc;
    req = 4'b0001; pulse_len = 3; cool_len = 2;
    expect_pulse(c + 1, 1, 3, 2, 0);
    wait_cyc(c + 1); req = '0;
    drain(40);

    // Round-robin fairness from rr_ptr = 0
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    c = cyc;
    req = 4'b1111; pulse_len = 1; cool_len = 0;
    for (int i = 0; i < 5; i++) expect_pulse(c + 1 + 3 * i, 1 << (i % 4), 1, 0, 0);
    wait_cyc(c + 13); req = '0;
    drain(40);

    // abort while IDLE is ignored
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-pulse, then an abort in COOL that must be ignored
    c = cyc;
    req = 4'b0010; pulse_len = 10; cool_len = 4;
    expect_pulse(c + 1, 2, 10, 4, 2);
    wait_cyc(c + 1); req = '0;
    wait_cyc(c + 3); abort = 1'b1;
    wait_cyc(c + 4); abort = 1'b0;
    wait_cyc(c + 5); abort = 1'b1;
    wait_cyc(c + 6); abort = 1'b0;
    drain(40);

    // Zero lengths, request held for two grants (wraps back to index 2)
    @(negedge clk);
    c = cyc;
    req = 4'b0100; pulse_len = 0; cool_len = 0;
    expect_pulse(c + 1, 4, 0, 0, 0);
    expect_pulse(c + 4, 4, 0, 0, 0);
    wait_cyc(c + 4); req = '0;
    drain(40);

    // Asynchronous reset in FIRE cycle 5
    @(negedge clk);
    c = cyc;
    req = 4'b0010; pulse_len = 20; cool_len = 0;
    push(K_GRANT, 2, c + 1);
    push(K_LIGHT, 4, c + 6);
    push(K_IDLE, 0, c + 6);
    wait_cyc(c + 1); req = '0;
    wait_cyc(c + 5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_light", int'(light), 0);
    check("async_reset_grant", int'(grant), 0);
    check("async_reset_busy",  int'(busy),  0);
    check("async_reset_done",  int'(done),  0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    drain(10);

    // After reset rr_ptr is 0, so index 1 wins over index 3
    @(negedge clk);
    c = cyc;
    req = 4'b1010; pulse_len = 2; cool_len = 0;
    expect_pulse(c + 1, 2, 2, 0, 0);
    wait_cyc(c + 1); req = '0;
    drain(40);

    // Request dropped in ARM, lengths changed during FIRE
    @(negedge clk);
    c = cyc;
    req = 4'b1000; pulse_len = 5; cool_len = 1;
    expect_pulse(c + 1, 8, 5, 1, 0);
    wait_cyc(c + 1); req = '0;
    wait_cyc(c + 3); pulse_len = 7; cool_len = 3;
    drain(40);

    // No grant may appear while req == 0
    repeat (12) @(negedge clk);
    drain(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      monitor_loop();
      stimulus();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
